// File: rtl/lights_pattern_decoder.sv
// Decoder for the 4-state rotating light pattern: locks onto position, tracks direction and net steps.
// Optional single-bit error correction is enabled by defining LIGHTS_SEC_CORRECT_EN.
module lights_pattern_decoder #(
  parameter int unsigned ERR_LIMIT = 3,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample,
  input  logic [7:0]       lights,
  input  logic             clear_fault,
  output logic [1:0]       pos,
  output logic             pos_valid,
  output logic             dir_up,
  output logic             step,
  output logic             bad,
  output logic             corrected,
  output logic             fault,
  output logic [CNT_W-1:0] net_count
);

  typedef enum logic [1:0] {HUNT, TRACK, FAULT} state_t;

  localparam logic [31:0]      CODES   = {8'b00111110, 8'b10001111, 8'b11100011, 8'b11111000};
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [3:0]       ERR_LIM = 4'(ERR_LIMIT);

  state_t     state;
  logic [3:0] err_cnt;
  logic [3:0] err_next;
  logic       legal;
  logic       fixed;
  logic [1:0] code;
  logic [1:0] d;
  logic       err_inc;

  always_comb begin
    legal = 1'b0;
    fixed = 1'b0;
    code  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (lights == CODES[i*8 +: 8]) begin
        legal = 1'b1;
        code  = 2'(i);
      end
`ifdef LIGHTS_SEC_CORRECT_EN
      // Minimum code distance is 4, so at most one code can be within distance 1.
      else if ($countones(lights ^ CODES[i*8 +: 8]) == 1) begin
        legal = 1'b1;
        fixed = 1'b1;
        code  = 2'(i);
      end
`endif
    end
  end

  always_comb begin
    d        = code - pos;
    err_next = err_cnt + 4'd1;
    err_inc  = (state == TRACK) && sample && (!legal || d == 2'd2);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= HUNT;
      pos       <= '0;
      pos_valid <= 1'b0;
      dir_up    <= 1'b0;
      step      <= 1'b0;
      bad       <= 1'b0;
      corrected <= 1'b0;
      fault     <= 1'b0;
      net_count <= '0;
      err_cnt   <= '0;
    end else begin
      step      <= 1'b0;
      bad       <= 1'b0;
      corrected <= 1'b0;
      case (state)
        HUNT: begin
          err_cnt <= '0;
          if (sample) begin
            if (legal) begin
              pos       <= code;
              pos_valid <= 1'b1;
              corrected <= fixed;
              state     <= TRACK;
            end else begin
              bad <= 1'b1;
            end
          end
        end
        TRACK: begin
          if (sample) begin
            if (!legal) begin
              bad <= 1'b1;
            end else begin
              corrected <= fixed;
              case (d)
                2'd0: ;
                2'd1: begin
                  step   <= 1'b1;
                  dir_up <= 1'b1;
                  pos    <= code;
                  if (net_count != CNT_MAX) net_count <= net_count + CNT_W'(1);
                end
                2'd3: begin
                  step   <= 1'b1;
                  dir_up <= 1'b0;
                  pos    <= code;
                  if (net_count != CNT_MIN) net_count <= net_count - CNT_W'(1);
                end
                2'd2: begin
                  bad <= 1'b1;
                  pos <= code;
                end
              endcase
            end
          end
          // A coincident clear_fault discards this sample's error increment entirely.
          if (clear_fault) begin
            err_cnt <= '0;
          end else if (err_inc) begin
            err_cnt <= err_next;
            if (err_next == ERR_LIM) begin
              state     <= FAULT;
              pos_valid <= 1'b0;
              fault     <= 1'b1;
            end
          end else if (sample) begin
            err_cnt <= '0;
          end
        end
        FAULT: begin
          if (clear_fault) begin
            state   <= HUNT;
            fault   <= 1'b0;
            err_cnt <= '0;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_lights_pattern_decoder.sv
// Table-driven scoreboard bench for lights_pattern_decoder (ERR_LIMIT=3, CNT_W=8) plus a CNT_W=2 instance.
module tb_lights_pattern_decoder;

  logic       clock = 1'b0;
  logic       reset, sample, clear_fault;
  logic [7:0] lights;
  logic [1:0] pos;
  logic       pos_valid, dir_up, step, bad, corrected, fault;
  logic [7:0] net_count;

  logic       s2_sample, s2_clear;
  logic [7:0] s2_lights;
  logic [1:0] s2_pos;
  logic       s2_pv, s2_du, s2_step, s2_bad, s2_corr, s2_fault;
  logic [1:0] s2_net;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clock = ~clock;

  lights_pattern_decoder #(.ERR_LIMIT(3), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .sample(sample), .lights(lights), .clear_fault(clear_fault),
    .pos(pos), .pos_valid(pos_valid), .dir_up(dir_up), .step(step), .bad(bad),
    .corrected(corrected), .fault(fault), .net_count(net_count)
  );

  lights_pattern_decoder #(.ERR_LIMIT(3), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .sample(s2_sample), .lights(s2_lights), .clear_fault(s2_clear),
    .pos(s2_pos), .pos_valid(s2_pv), .dir_up(s2_du), .step(s2_step), .bad(s2_bad),
    .corrected(s2_corr), .fault(s2_fault), .net_count(s2_net)
  );

  typedef struct {
    logic       rst, smp, clr;
    logic [7:0] lt;
    logic [1:0] pos;
    logic       pv, du, st, bd, cr, flt;
    logic [7:0] cnt;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[23];

  function automatic vec_t mk(input logic rst, smp, clr, input logic [7:0] lt, input logic [1:0] p,
                              input logic pv, du, st, bd, cr, flt, input logic [7:0] cnt);
    vec_t v;
    v.rst = rst; v.smp = smp; v.clr = clr; v.lt = lt; v.pos = p;
    v.pv = pv; v.du = du; v.st = st; v.bd = bd; v.cr = cr; v.flt = flt; v.cnt = cnt;
    return v;
  endfunction

  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    logic [15:0] act, exp_v;
    reset = v.rst; sample = v.smp; clear_fault = v.clr; lights = v.lt;
    sb.push_back(v);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    act   = {pos, pos_valid, dir_up, step, bad, corrected, fault, net_count};
    exp_v = {e.pos, e.pv, e.du, e.st, e.bd, e.cr, e.flt, e.cnt};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got pos=%0d pv=%b up=%b step=%b bad=%b corr=%b fault=%b cnt=%0d, want pos=%0d pv=%b up=%b step=%b bad=%b corr=%b fault=%b cnt=%0d",
               tag, pos, pos_valid, dir_up, step, bad, corrected, fault, $signed(net_count),
               e.pos, e.pv, e.du, e.st, e.bd, e.cr, e.flt, $signed(e.cnt));
    end
  endtask

  task automatic apply2(input string tag, input logic [7:0] lt, input logic exp_st, input logic [1:0] exp_cnt);
    s2_sample = 1'b1; s2_lights = lt;
    @(posedge clock);
    #1;
    checks++;
    if ({s2_step, s2_net} !== {exp_st, exp_cnt}) begin
      errors++;
      $display("FAIL %s: got step=%b cnt=%b, want step=%b cnt=%b", tag, s2_step, s2_net, exp_st, exp_cnt);
    end
  endtask

  initial begin
    reset = 1'b0; sample = 1'b0; clear_fault = 1'b0; lights = '0;
    s2_sample = 1'b0; s2_clear = 1'b0; s2_lights = '0;

    //             rst smp clr lights        pos pv du st bd cr flt cnt
    tbl[0]  = mk(1, 1, 0, 8'hF8, 0, 1, 0, 0, 0, 0, 0, 8'd0);
    tbl[1]  = mk(1, 1, 0, 8'hE3, 1, 1, 1, 1, 0, 0, 0, 8'd1);
    tbl[2]  = mk(1, 1, 0, 8'h8F, 2, 1, 1, 1, 0, 0, 0, 8'd2);
    tbl[3]  = mk(1, 1, 0, 8'h3E, 3, 1, 1, 1, 0, 0, 0, 8'd3);
    tbl[4]  = mk(1, 1, 0, 8'hF8, 0, 1, 1, 1, 0, 0, 0, 8'd4);
    tbl[5]  = mk(1, 0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 8'd4);
    tbl[6]  = mk(1, 1, 0, 8'h3E, 3, 1, 0, 1, 0, 0, 0, 8'd3);
    tbl[7]  = mk(1, 1, 0, 8'h8F, 2, 1, 0, 1, 0, 0, 0, 8'd2);
    tbl[8]  = mk(1, 1, 0, 8'hF8, 0, 1, 0, 0, 1, 0, 0, 8'd2);
    tbl[9]  = mk(1, 1, 0, 8'hF8, 0, 1, 0, 0, 0, 0, 0, 8'd2);
    tbl[10] = mk(1, 1, 0, 8'hE3, 1, 1, 1, 1, 0, 0, 0, 8'd3);
    tbl[11] = mk(1, 1, 0, 8'h00, 1, 1, 1, 0, 1, 0, 0, 8'd3);
    tbl[12] = mk(1, 1, 0, 8'h00, 1, 1, 1, 0, 1, 0, 0, 8'd3);
    tbl[13] = mk(1, 1, 0, 8'h00, 1, 0, 1, 0, 1, 0, 1, 8'd3);
    tbl[14] = mk(1, 1, 0, 8'h8F, 1, 0, 1, 0, 0, 0, 1, 8'd3);
    tbl[15] = mk(1, 1, 1, 8'h8F, 1, 0, 1, 0, 0, 0, 0, 8'd3);
    tbl[16] = mk(1, 1, 0, 8'h8F, 2, 1, 1, 0, 0, 0, 0, 8'd3);
    tbl[17] = mk(1, 1, 0, 8'hE3, 1, 1, 0, 1, 0, 0, 0, 8'd2);
    tbl[18] = mk(1, 1, 0, 8'hF8, 0, 1, 0, 1, 0, 0, 0, 8'd1);
`ifdef LIGHTS_SEC_CORRECT_EN
    tbl[19] = mk(1, 1, 0, 8'hE7, 1, 1, 1, 1, 0, 1, 0, 8'd2);
    tbl[20] = mk(1, 1, 1, 8'h00, 1, 1, 1, 0, 1, 0, 0, 8'd2);
    tbl[21] = mk(1, 1, 0, 8'h00, 1, 1, 1, 0, 1, 0, 0, 8'd2);
    tbl[22] = mk(1, 1, 0, 8'h00, 1, 1, 1, 0, 1, 0, 0, 8'd2);
`else
    tbl[19] = mk(1, 1, 0, 8'hE7, 0, 1, 0, 0, 1, 0, 0, 8'd1);
    tbl[20] = mk(1, 1, 1, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'd1);
    tbl[21] = mk(1, 1, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'd1);
    tbl[22] = mk(1, 1, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'd1);
`endif

    #1;
    apply("reset_a", mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'd0));
    apply("reset_b", mk(0, 1, 0, 8'hF8, 0, 0, 0, 0, 0, 0, 0, 8'd0));

    for (int i = 0; i < 23; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Reset mid-TRACK, then an illegal sample while hunting.
    apply("reset_track", mk(0, 1, 0, 8'h3E, 0, 0, 0, 0, 0, 0, 0, 8'd0));
    apply("hunt_bad",    mk(1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'd0));
    apply("hunt_clr",    mk(1, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'd0));

    // Drive into FAULT, then reset while faulted.
    apply("lock2",       mk(1, 1, 0, 8'h8F, 2, 1, 0, 0, 0, 0, 0, 8'd0));
    apply("f_bad1",      mk(1, 1, 0, 8'h55, 2, 1, 0, 0, 1, 0, 0, 8'd0));
    apply("f_skip2",     mk(1, 1, 0, 8'hF8, 0, 1, 0, 0, 1, 0, 0, 8'd0));
    apply("f_bad3",      mk(1, 1, 0, 8'hFF, 0, 0, 0, 0, 1, 0, 1, 8'd0));
    apply("fault_hold",  mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'd0));
    apply("reset_fault", mk(0, 1, 0, 8'hE3, 0, 0, 0, 0, 0, 0, 0, 8'd0));
    apply("relock0",     mk(1, 1, 0, 8'hE3, 1, 1, 0, 0, 0, 0, 0, 8'd0));

    // Saturation of a 2-bit counter.
    apply2("s2_lock", 8'hF8, 1'b0, 2'b00);
    apply2("s2_up1",  8'hE3, 1'b1, 2'b01);
    apply2("s2_up2",  8'h8F, 1'b1, 2'b01);
    apply2("s2_up3",  8'h3E, 1'b1, 2'b01);
    apply2("s2_up4",  8'hF8, 1'b1, 2'b01);
    apply2("s2_dn1",  8'h3E, 1'b1, 2'b00);
    apply2("s2_dn2",  8'h8F, 1'b1, 2'b11);
    apply2("s2_dn3",  8'hE3, 1'b1, 2'b10);
    apply2("s2_dn4",  8'hF8, 1'b1, 2'b10);
    s2_sample = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
